btb_update_ctrl: RTL and testbench

- Branch-resolution and BTB write-port scheduler for the pipelined core.
- Sits at EX:
  - evaluates conditional branches against the g/z/l flags;
  - compares the outcome with the prediction carried down from fetch;
  - issues redirect/flush on a mispredict.
- Owns the BTB's single write port. Write sources, in priority order: whole-table invalidate sweep, then a small queue of pending BTB updates.

---
 rtl/btb_update_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl
//   Resolves conditional branches at EX against the g/z/l flags, compares the
//   outcome with the fetch-time prediction and issues a registered redirect
//   plus a multi-cycle IF/ID flush on a mispredict. It also owns the single
//   BTB write port. A whole-table invalidate sweep has priority over draining
//   a small FIFO of pending BTB updates produced by mispredicts.
//
//   Optional feature macro: BTB_STATS_EN
//     defined   : br_cnt / mp_cnt count resolved branches / mispredicts (wrap)
//     undefined : br_cnt / mp_cnt are tied to 0, no counter registers exist
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   ex_valid, ex_pc,
//   ex_opcode, ex_cond,
//   ex_target                EX-stage instruction and computed branch target
//   ex_pred_taken,
//   ex_pred_target           prediction carried down from fetch
//   gflag, zflag, lflag      condition flags
//   inv_req / inv_ack        invalidate request (level) / completion pulse
//   redirect_valid/_pc       one-cycle fetch redirect
//   flush                    squash IF/ID (FLUSH_CYCLES cycles per mispredict)
//   stall                    hold fetch while the sweep runs
//   btb_wr_*                 BTB write port
//   drop_cnt                 saturating count of updates lost to a full FIFO
//   br_cnt, mp_cnt           optional statistics counters
module btb_update_ctrl #(
  parameter int         IDX_W        = 4,
  parameter int         QDEPTH       = 2,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [3:0] BR_OPCODE    = 4'b1001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [15:0]      ex_pc,
  input  logic [3:0]       ex_opcode,
  input  logic [1:0]       ex_cond,
  input  logic [15:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [15:0]      ex_pred_target,
  input  logic             gflag,
  input  logic             zflag,
  input  logic             lflag,
  input  logic             inv_req,
  output logic             inv_ack,
  output logic             redirect_valid,
  output logic [15:0]      redirect_pc,
  output logic             flush,
  output logic             stall,
  output logic             btb_wr_en,
  output logic [IDX_W-1:0] btb_wr_index,
  output logic [15:0]      btb_wr_tag,
  output logic [15:0]      btb_wr_target,
  output logic             btb_wr_valid,
  output logic [7:0]       drop_cnt,
  output logic [15:0]      br_cnt,
  output logic [15:0]      mp_cnt
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);
  localparam logic [IDX_W-1:0] SWEEP_LAST = {IDX_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] tag;
    logic [15:0] target;
    logic        valid;
  } upd_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- stage p0: branch resolution (combinational at EX) ----
  logic vld_p0;
  logic taken_p0;
  logic mispredict_p0;
  upd_t enq_entry_p0;

  always_comb begin
    unique case (ex_cond)
      2'b00:   taken_p0 = zflag;
      2'b01:   taken_p0 = gflag;
      2'b10:   taken_p0 = lflag;
      default: taken_p0 = 1'b1;
    endcase
  end

  // ex_valid is ignored while the front end is being squashed.
  assign vld_p0        = ex_valid && (ex_opcode == BR_OPCODE) && !flush;
  assign mispredict_p0 = vld_p0 &&
                         ((taken_p0 != ex_pred_taken) ||
                          (taken_p0 && ex_pred_taken && (ex_target != ex_pred_target)));

  // Every mispredict needs a BTB fix-up: taken installs the target, a false
  // taken prediction clears the entry.
  always_comb begin
    enq_entry_p0.tag    = ex_pc;
    enq_entry_p0.target = taken_p0 ? ex_target : 16'h0000;
    enq_entry_p0.valid  = taken_p0;
  end

  // ---- stage p1: registered redirect / flush ----
  logic            vld_p1;
  logic [15:0]     redirect_pc_p1;
  logic [FC_W-1:0] flush_cnt_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1         <= 1'b0;
      redirect_pc_p1 <= 16'h0000;
      flush_cnt_p1   <= '0;
    end else begin
      vld_p1 <= mispredict_p0;
      if (mispredict_p0) begin
        redirect_pc_p1 <= taken_p0 ? ex_target : ex_pc + 16'd1;
        flush_cnt_p1   <= FC_W'(FLUSH_CYCLES);
      end else if (flush_cnt_p1 != '0) begin
        flush_cnt_p1 <= flush_cnt_p1 - FC_W'(1);
      end
    end
  end

  assign redirect_valid = vld_p1;
  assign redirect_pc    = redirect_pc_p1;
  assign flush          = (flush_cnt_p1 != '0);

  // ---- pending-update FIFO ----
  upd_t             q_mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   q_count;
  logic             q_full;
  logic             q_empty;
  logic             pop;
  logic             push;
  logic             drop;
  upd_t             head;

  assign q_full  = (q_count == (PTR_W+1)'(QDEPTH));
  assign q_empty = (q_count == '0);
  assign head    = q_mem[rd_ptr];
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push    = mispredict_p0 && (!q_full || pop);
  assign drop    = mispredict_p0 && q_full && !pop;

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= enq_entry_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      drop_cnt <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   q_count <= q_count + (PTR_W+1)'(1);
        2'b01:   q_count <= q_count - (PTR_W+1)'(1);
        default: q_count <= q_count;
      endcase
      if (drop) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  // ---- write-port scheduler ----
  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] sweep_idx;
  logic             sweep_start;
  logic             inv_armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sweep_idx <= '0;
      inv_armed <= 1'b1;
    end else begin
      state_q <= state_d;
      if (sweep_start)             sweep_idx <= '0;
      else if (state_q == S_SWEEP) sweep_idx <= sweep_idx + IDX_W'(1);
      // A held inv_req must be seen low once before it can start a new sweep.
      if (!inv_req)         inv_armed <= 1'b1;
      else if (sweep_start) inv_armed <= 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    sweep_start   = 1'b0;
    pop           = 1'b0;
    inv_ack       = 1'b0;
    stall         = 1'b0;
    btb_wr_en     = 1'b0;
    btb_wr_index  = '0;
    btb_wr_tag    = 16'h0000;
    btb_wr_target = 16'h0000;
    btb_wr_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (inv_req && inv_armed) begin
          state_d     = S_SWEEP;
          sweep_start = 1'b1;
        end else if (!q_empty) begin
          pop           = 1'b1;
          btb_wr_en     = 1'b1;
          btb_wr_index  = head.tag[IDX_W-1:0];
          btb_wr_tag    = head.tag;
          btb_wr_target = head.target;
          btb_wr_valid  = head.valid;
        end
      end
      S_SWEEP: begin
        stall        = 1'b1;
        btb_wr_en    = 1'b1;
        btb_wr_index = sweep_idx;
        if (sweep_idx == SWEEP_LAST) state_d = S_ACK;
      end
      S_ACK: begin
        inv_ack = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- optional statistics ----
`ifdef BTB_STATS_EN
  logic [15:0] br_cnt_q;
  logic [15:0] mp_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q <= 16'h0000;
      mp_cnt_q <= 16'h0000;
    end else begin
      if (vld_p0)        br_cnt_q <= br_cnt_q + 16'd1;
      if (mispredict_p0) mp_cnt_q <= mp_cnt_q + 16'd1;
    end
  end

  assign br_cnt = br_cnt_q;
  assign mp_cnt = mp_cnt_q;
`else
  assign br_cnt = 16'h0000;
  assign mp_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: branch vector table, invalidate sweep,
// overflow during sweep and reset mid-sweep. Expected BTB writes and
// redirects are queued as stimulus is driven and consumed by a monitor.
module tb_btb_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic [3:0]  ex_opcode;
  logic [1:0]  ex_cond;
  logic [15:0] ex_target;
  logic        ex_pred_taken;
  logic [15:0] ex_pred_target;
  logic        gflag, zflag, lflag;
  logic        inv_req;
  logic        inv_ack;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flush;
  logic        stall;
  logic        btb_wr_en;
  logic [3:0]  btb_wr_index;
  logic [15:0] btb_wr_tag;
  logic [15:0] btb_wr_target;
  logic        btb_wr_valid;
  logic [7:0]  drop_cnt;
  logic [15:0] br_cnt;
  logic [15:0] mp_cnt;

  btb_update_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_cond(ex_cond),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .gflag(gflag), .zflag(zflag), .lflag(lflag),
    .inv_req(inv_req), .inv_ack(inv_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .stall(stall),
    .btb_wr_en(btb_wr_en), .btb_wr_index(btb_wr_index), .btb_wr_tag(btb_wr_tag),
    .btb_wr_target(btb_wr_target), .btb_wr_valid(btb_wr_valid),
    .drop_cnt(drop_cnt), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  logic [36:0] wq [$];   // {index, tag, target, valid}
  logic [15:0] rq [$];   // redirect pc

  typedef struct {
    logic [3:0]  op;
    logic [15:0] pc;
    logic [1:0]  cond;
    logic        g, z, l;
    logic        pt;
    logic [15:0] ptgt;
    logic [15:0] tgt;
    logic        mp;
    logic [15:0] rpc;
    logic [15:0] wtgt;
    logic        wv;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (rst && mon_en) begin
      if (btb_wr_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 64'({btb_wr_index, btb_wr_tag, btb_wr_target, btb_wr_valid}), 64'h0);
          if (btb_wr_index == 4'h0 && btb_wr_tag == 16'h0 && btb_wr_target == 16'h0 && !btb_wr_valid) begin
            errors++;
            $display("FAIL unexpected_write: got zero-write expected none");
          end
        end else begin
          chk("btb_write", 64'({btb_wr_index, btb_wr_tag, btb_wr_target, btb_wr_valid}), 64'(wq.pop_front()));
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) chk("unexpected_redirect", 64'(redirect_pc), 64'hDEAD_0000);
        else chk("redirect_pc", 64'(redirect_pc), 64'(rq.pop_front()));
      end
    end
  end

  task automatic drive_br(input logic [3:0] op, input logic [15:0] pc, input logic [1:0] cond,
                          input logic g, input logic z, input logic l, input logic pt,
                          input logic [15:0] ptgt, input logic [15:0] tgt);
    ex_valid = 1'b1; ex_opcode = op; ex_pc = pc; ex_cond = cond;
    gflag = g; zflag = z; lflag = l;
    ex_pred_taken = pt; ex_pred_target = ptgt; ex_target = tgt;
  endtask

  // Starts and ends on a falling edge.
  task automatic run_vec(input vec_t v);
    drive_br(v.op, v.pc, v.cond, v.g, v.z, v.l, v.pt, v.ptgt, v.tgt);
    if (v.mp) begin
      rq.push_back(v.rpc);
      wq.push_back({v.pc[3:0], v.pc, v.wtgt, v.wv});
    end
    @(posedge clk); #1;
    chk("redir_vld", 64'(redirect_valid), 64'(v.mp));
    chk("flush_c1", 64'(flush), 64'(v.mp));
    @(negedge clk);
    ex_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_c2", 64'(flush), 64'(v.mp));
    chk("redir_pulse", 64'(redirect_valid), 64'h0);
    @(posedge clk); #1;
    chk("flush_c3", 64'(flush), 64'h0);
    @(negedge clk);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 16; i++) wq.push_back({4'(i), 16'h0, 16'h0, 1'b0});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stall_n, ack_n, last_stall, ack_at, n;
    logic [5:0]  ctl;
    logic [51:0] dat;

    //            op     pc        cond   g     z     l     pt    ptgt      tgt       mp    rpc       wtgt      wv
    vecs[0] = '{4'h9, 16'h0002, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0010, 1'b1, 16'h0010, 16'h0010, 1'b1};
    vecs[1] = '{4'h9, 16'h0002, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0010, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{4'h9, 16'h0003, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0030, 16'h0030, 1'b1, 16'h0004, 16'h0000, 1'b0};
    vecs[3] = '{4'h9, 16'h1234, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0200, 1'b1, 16'h0200, 16'h0200, 1'b1};
    vecs[4] = '{4'h9, 16'hFFFF, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0070, 16'h0070, 1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[5] = '{4'h9, 16'h0005, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0ABC, 1'b1, 16'h0ABC, 16'h0ABC, 1'b1};
    vecs[6] = '{4'h9, 16'h0006, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[7] = '{4'h3, 16'h0008, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0090, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[8] = '{4'h9, 16'h000A, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0055, 16'h0066, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vecs[9] = '{4'h9, 16'h0007, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0050, 16'h0050, 1'b1, 16'h0008, 16'h0000, 1'b0};

    rst = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_opcode = '0; ex_cond = '0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    gflag = 1'b0; zflag = 1'b0; lflag = 1'b0; inv_req = 1'b0;
    #1;
    ctl = {inv_ack, redirect_valid, flush, stall, btb_wr_en, btb_wr_valid};
    chk("reset_ctl", 64'(ctl), 64'h0);
    chk("reset_drop", 64'(drop_cnt), 64'h0);
    chk("reset_stats", 64'({br_cnt, mp_cnt}), 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Branch vector table
    foreach (vecs[i]) run_vec(vecs[i]);

    // Invalidate with inv_req held high well past the ack: exactly one sweep
    push_sweep();
    inv_req = 1'b1;
    stall_n = 0; ack_n = 0; last_stall = -1; ack_at = -1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (stall) begin stall_n++; last_stall = i; end
      if (inv_ack) begin ack_n++; ack_at = i; end
    end
    chk("sweep_stall_cycles", 64'(stall_n), 64'd16);
    chk("sweep_ack_count", 64'(ack_n), 64'd1);
    chk("sweep_ack_follows", 64'(ack_at), 64'(last_stall + 1));
    @(negedge clk);
    inv_req = 1'b0;
    repeat (2) @(negedge clk);

    // Three mispredicts during a sweep: two queued, one dropped
    inv_req = 1'b1;
    push_sweep();
    wq.push_back({4'h1, 16'h0021, 16'h0100, 1'b1});
    wq.push_back({4'h2, 16'h0032, 16'h0000, 1'b0});
    rq.push_back(16'h0100);
    rq.push_back(16'h0033);
    rq.push_back(16'h0200);
    @(negedge clk);
    inv_req = 1'b0;
    drive_br(4'h9, 16'h0021, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0100);
    @(negedge clk); ex_valid = 1'b0;
    repeat (2) @(negedge clk);
    drive_br(4'h9, 16'h0032, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0077, 16'h0077);
    @(negedge clk); ex_valid = 1'b0;
    repeat (2) @(negedge clk);
    drive_br(4'h9, 16'h0043, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0200);
    @(negedge clk); ex_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk("drop_cnt", 64'(drop_cnt), 64'd1);
    n = 0;
    while (wq.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk("wr_queue_drained", 64'(wq.size()), 64'd0);
    chk("redir_queue_drained", 64'(rq.size()), 64'd0);

    // Reset mid-sweep with an update pending
    mon_en = 1'b0;
    inv_req = 1'b1;
    @(negedge clk);
    inv_req = 1'b0;
    drive_br(4'h9, 16'h0009, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0020);
    @(negedge clk); ex_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_stall", 64'(stall), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    ctl = {inv_ack, redirect_valid, flush, stall, btb_wr_en, btb_wr_valid};
    dat = {redirect_pc, btb_wr_index, btb_wr_tag, btb_wr_target};
    chk("midrst_ctl", 64'(ctl), 64'h0);
    chk("midrst_data", 64'(dat), 64'h0);
    chk("midrst_drop", 64'(drop_cnt), 64'h0);
    wq.delete();
    rq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (redirect_valid || stall || flush) n++;
    end
    chk("post_reset_quiet", 64'(n), 64'd0);
    @(negedge clk);
    run_vec(vecs[0]);
    n = 0;
    while (wq.size() != 0 && n < 10) begin @(negedge clk); n++; end
    chk("final_drained", 64'(wq.size() + rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
